// File: rtl/mul64_issue_ctl.sv
// Issue/sign-correction wrapper around the ce-gated unsigned 64x64 multiplier.
// It tracks valid/tag/correction beside the multiplier and drives a stallable output register.
module mul64_issue_ctl #(
  parameter int MLAT = 11,
  parameter int TAGW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_a,
  input  logic [63:0]     in_b,
  input  logic [1:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            m_ce,
  output logic [63:0]     m_a,
  output logic [63:0]     m_b,
  input  logic [127:0]    m_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_prod,
  output logic [TAGW-1:0] out_tag,
  output logic            idle
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds valid and its payload steady until that edge; ready never
  // depends on valid on the same side (in_ready only sees out_ready and flush).

  logic            stall;
  logic            accept;
  logic            sa;
  logic            sb;
  logic [63:0]     corr_in;
  logic [MLAT-1:0] pv;
  logic [TAGW-1:0] ptag  [MLAT];
  logic [63:0]     pcorr [MLAT];

  assign stall    = out_valid & ~out_ready;
  assign m_ce     = ~stall;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;
  assign m_a      = in_a;
  assign m_b      = in_b;
  assign idle     = ~(|pv) & ~out_valid;

  // Reserved op 3 falls through as unsigned because neither sign flag is set.
  assign sa = (in_op == 2'd1) | (in_op == 2'd2);
  assign sb = (in_op == 2'd1);

  // Unsigned product of the raw bit patterns overshoots the signed product by
  // (a<0 ? b : 0)*2^64 + (b<0 ? a : 0)*2^64; only the low 64 bits of that term matter.
  assign corr_in = ((sa & in_a[63]) ? in_b : 64'd0) + ((sb & in_b[63]) ? in_a : 64'd0);

  // Side pipeline shifts only with m_ce so it stays aligned with the multiplier data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < MLAT; i++) begin
        ptag[i]  <= '0;
        pcorr[i] <= '0;
      end
    end else begin
      if (m_ce) begin
        pv       <= {pv[MLAT-2:0], accept};
        ptag[0]  <= in_tag;
        pcorr[0] <= corr_in;
        for (int i = 1; i < MLAT; i++) begin
          ptag[i]  <= ptag[i-1];
          pcorr[i] <= pcorr[i-1];
        end
      end
      if (flush) begin
        pv <= '0;
      end
    end
  end

  // Flush wins over a concurrent consumer handshake: the held result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (pv[MLAT-1]) begin
        out_prod  <= m_o - {pcorr[MLAT-1], 64'd0};
        out_tag   <= ptag[MLAT-1];
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul64_issue_ctl.sv
// Bench for mul64_issue_ctl: behavioural multiplier, signed-arithmetic reference model,
// scoreboard queue filled at accept and drained by a monitor at each output handshake.
module tb_mul64_issue_ctl;

  localparam int MLAT = 11;
  localparam int TAGW = 6;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_a;
  logic [63:0]     in_b;
  logic [1:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            m_ce;
  logic [63:0]     m_a;
  logic [63:0]     m_b;
  logic [127:0]    m_o;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_prod;
  logic [TAGW-1:0] out_tag;
  logic            idle;

  mul64_issue_ctl #(.MLAT(MLAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .m_ce(m_ce), .m_a(m_a), .m_b(m_b), .m_o(m_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag), .idle(idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- multiplier model: MLAT ce-gated stages ----------------
  logic [127:0] mpipe [MLAT];
  always @(posedge clk) begin
    if (m_ce) begin
      mpipe[0] <= {64'd0, m_a} * {64'd0, m_b};
      for (int i = 1; i < MLAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign m_o = mpipe[MLAT-1];

  // ---------------- reference model ----------------
  function automatic logic [127:0] ref_prod(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] xa;
    logic [127:0] xb;
    xa = {64'd0, a};
    xb = {64'd0, b};
    if (op == 2'd1 || op == 2'd2) xa = {{64{a[63]}}, a};
    if (op == 2'd1)               xb = {{64{b[63]}}, b};
    return xa * xb;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;
  int n_results;
  logic [127+TAGW:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [127+TAGW:0] e;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {127'd0, in_ready}, 128'd0);
        check("stall_m_ce", {127'd0, m_ce}, 128'd0);
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got prod %h tag %h with no result pending",
                   out_prod, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("prod", out_prod, e[127+TAGW:TAGW]);
          check("tag", {{(128-TAGW){1'b0}}, out_tag}, {{(128-TAGW){1'b0}}, e[TAGW-1:0]});
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({ref_prod(in_op, in_a, in_b), in_tag});
    end
  end

  // ---------------- consumer backpressure ----------------
  logic bp_mode;
  initial begin
    bp_mode = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Leaves in_valid high so calls chain back-to-back; returns at posedge+1 after the accept.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAGW-1:0] tag);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: in_ready low for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  // One op with out_ready high; checks the accept-to-out_valid distance is MLAT+1 cycles.
  task automatic single(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAGW-1:0] tag);
    int n;
    out_ready = 1'b1;
    issue(op, a, b, tag);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("latency", 128'(n), 128'(MLAT + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    check("drain_idle", {127'd0, idle}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    n_checks  = 0;
    n_errors  = 0;
    n_results = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_prod", out_prod, 128'd0);
    check("rst_out_tag", {{(128-TAGW){1'b0}}, out_tag}, 128'd0);
    check("rst_idle", {127'd0, idle}, 128'd1);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed values
    single(2'd0, 64'd3, 64'd5, 6'h11);
    check("unsigned_3x5", out_prod, 128'd15);
    check("unsigned_tag", {{(128-TAGW){1'b0}}, out_tag}, 128'h11);
    drain();
    single(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h01);
    check("ss_m1xm1", out_prod, 128'd1);
    drain();
    single(2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'h02);
    check("ss_m2x3", out_prod, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    drain();
    single(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 6'h03);
    check("su_mixed", out_prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002);
    drain();
    single(2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 6'h04);
    check("uu_big", out_prod, 128'hFFFF_FFFF_FFFF_FFFD_0000_0000_0000_0002);
    drain();
    single(2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 6'h05);
    check("op3_as_uu", out_prod, 128'hFFFF_FFFF_FFFF_FFFD_0000_0000_0000_0002);
    drain();

    // back-to-back stream under random backpressure
    r0 = n_results;
    bp_mode = 1'b1;
    for (int i = 0; i < 20; i++) issue(2'd0, 64'(i), 64'(i + 1), TAGW'(i));
    in_valid = 1'b0;
    drain();
    bp_mode = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 128'(n_results - r0), 128'd20);

    // randomized mix of ops, operands and gaps
    bp_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
      issue(2'($urandom_range(0, 3)), a, b, TAGW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    drain();
    bp_mode = 1'b0;
    out_ready = 1'b1;

    // flush discards everything in flight
    r0 = n_results;
    for (int i = 0; i < 5; i++) issue(2'd1, 64'(i + 100), 64'(i + 9), TAGW'(i + 1));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    single(2'd0, 64'd7, 64'd6, 6'h2A);
    check("flush_prod", out_prod, 128'd42);
    check("flush_tag", {{(128-TAGW){1'b0}}, out_tag}, 128'h2A);
    drain();
    check("flush_count", 128'(n_results - r0), 128'd1);

    // asynchronous reset mid-flight
    for (int i = 0; i < 8; i++) issue(2'd0, 64'(i + 3), 64'(i + 4), TAGW'(i));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check("arst_out_prod", out_prod, 128'd0);
    check("arst_idle", {127'd0, idle}, 128'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    r0 = n_results;
    single(2'd0, 64'h1_0000_0000, 64'h1_0000_0000, 6'h3F);
    check("post_rst_prod", out_prod, 128'h1_0000_0000_0000_0000);
    drain();
    check("post_rst_count", 128'(n_results - r0), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
